// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: deframes 11-bit PS/2 frames, tracks E0/F0 prefixes, translates make codes to ASCII.
// Latency: key/key_valid registered at the clk edge where the stop-bit fall is seen (strobe high the next cycle).
// Backpressure: none; key_valid and frame_err are one-cycle strobes the consumer must take when offered.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset, clears all state
//   ps2_clk    raw PS/2 clock line (asynchronous, synchronized here)
//   ps2_data   raw PS/2 data line (asynchronous, synchronized here)
//   key        ASCII of the last accepted key, held between strobes
//   key_valid  one-cycle strobe, key is valid while high
//   frame_err  one-cycle strobe on parity, stop-bit or timeout error
module ps2_kb_rx #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    // Everything resets to 1, the idle bus level, so a reset never
    // manufactures a falling edge on release.
    logic clk_s1;
    logic clk_s2;
    logic clk_prev;
    logic data_s1;
    logic data_s2;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    // Clock and data share the same synchronizer depth, so data sampled
    // alongside the detected fall is the value the device drove before it.
    assign fall = clk_prev & ~clk_s2;

    // ------------------------------------------------------------------
    // Scan-code to ASCII table. Bit 8 flags a mapped code.
    // ------------------------------------------------------------------
    function automatic logic [8:0] lookup(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h61}; // a
            8'h32: r = {1'b1, 8'h62}; // b
            8'h21: r = {1'b1, 8'h63}; // c
            8'h23: r = {1'b1, 8'h64}; // d
            8'h24: r = {1'b1, 8'h65}; // e
            8'h2B: r = {1'b1, 8'h66}; // f
            8'h34: r = {1'b1, 8'h67}; // g
            8'h33: r = {1'b1, 8'h68}; // h
            8'h43: r = {1'b1, 8'h69}; // i
            8'h3B: r = {1'b1, 8'h6A}; // j
            8'h42: r = {1'b1, 8'h6B}; // k
            8'h4B: r = {1'b1, 8'h6C}; // l
            8'h3A: r = {1'b1, 8'h6D}; // m
            8'h31: r = {1'b1, 8'h6E}; // n
            8'h44: r = {1'b1, 8'h6F}; // o
            8'h4D: r = {1'b1, 8'h70}; // p
            8'h15: r = {1'b1, 8'h71}; // q
            8'h2D: r = {1'b1, 8'h72}; // r
            8'h1B: r = {1'b1, 8'h73}; // s
            8'h2C: r = {1'b1, 8'h74}; // t
            8'h3C: r = {1'b1, 8'h75}; // u
            8'h2A: r = {1'b1, 8'h76}; // v
            8'h1D: r = {1'b1, 8'h77}; // w
            8'h22: r = {1'b1, 8'h78}; // x
            8'h35: r = {1'b1, 8'h79}; // y
            8'h1A: r = {1'b1, 8'h7A}; // z
            8'h45: r = {1'b1, 8'h30}; // 0
            8'h16: r = {1'b1, 8'h31}; // 1
            8'h1E: r = {1'b1, 8'h32}; // 2
            8'h26: r = {1'b1, 8'h33}; // 3
            8'h25: r = {1'b1, 8'h34}; // 4
            8'h2E: r = {1'b1, 8'h35}; // 5
            8'h36: r = {1'b1, 8'h36}; // 6
            8'h3D: r = {1'b1, 8'h37}; // 7
            8'h3E: r = {1'b1, 8'h38}; // 8
            8'h46: r = {1'b1, 8'h39}; // 9
            8'h29: r = {1'b1, 8'h20}; // space
            8'h5A: r = {1'b1, 8'h0D}; // enter, the line terminator downstream
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Frame FSM, timeout and decoder state
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_nxt;
    logic [7:0]      shreg;
    logic [7:0]      shreg_nxt;
    logic            par_bit;
    logic            par_bit_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            brk;
    logic            brk_nxt;
    logic            ext;
    logic            ext_nxt;
    logic [7:0]      key_nxt;
    logic            key_valid_nxt;
    logic            frame_err_nxt;

    logic            par_ok;
    logic            timeout;
    logic [8:0]      lut;

    // Odd parity over data plus parity bit.
    assign par_ok  = ^{shreg, par_bit};
    assign lut     = lookup(shreg);
    // A fall on the same cycle keeps the frame alive.
    assign timeout = (state != IDLE) && !fall &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            key       <= 8'h00;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            par_bit   <= par_bit_nxt;
            to_cnt    <= to_cnt_nxt;
            brk       <= brk_nxt;
            ext       <= ext_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        par_bit_nxt   = par_bit;
        brk_nxt       = brk;
        ext_nxt       = ext;
        key_nxt       = key;
        key_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;

        if (fall || state == IDLE) begin
            to_cnt_nxt = '0;
        end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end

        case (state)
            IDLE: begin
                // A 1 in the start position is line noise, not an error.
                if (fall && !data_s2) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_nxt[bit_cnt] = data_s2;
                    bit_cnt_nxt        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_bit_nxt = data_s2;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_nxt = IDLE;
                    if (data_s2 && par_ok) begin
                        if (shreg == 8'hE0) begin
                            ext_nxt = 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_nxt = 1'b1;
                        end else if (brk) begin
                            // Release of a key: swallow it and drop any prefix.
                            brk_nxt = 1'b0;
                            ext_nxt = 1'b0;
                        end else if (ext) begin
                            // Only keypad enter is meaningful among extended keys.
                            ext_nxt = 1'b0;
                            if (shreg == 8'h5A) begin
                                key_nxt       = 8'h0D;
                                key_valid_nxt = 1'b1;
                            end
                        end else if (lut[8]) begin
                            key_nxt       = lut[7:0];
                            key_valid_nxt = 1'b1;
                        end
                    end else begin
                        // A corrupted byte may have been a prefix, so forget both.
                        frame_err_nxt = 1'b1;
                        brk_nxt       = 1'b0;
                        ext_nxt       = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (timeout) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
            brk_nxt       = 1'b0;
            ext_nxt       = 1'b0;
        end
    end

endmodule

// File: doc/ps2_kb_rx.md
Name: ps2_kb_rx

Overview:
- Upstream stage of KbBuffer. Receives PS/2 keyboard frames, tracks make/break/extended prefixes and translates make codes to ASCII.
- Emits one-cycle key/key_valid pulses that drive KbBuffer directly. ENTER maps to 0x0D, the line terminator KbBuffer expects.
- Single system clock domain. The PS/2 clock and data lines are sampled as ordinary asynchronous inputs.

Parameters:
- TIMEOUT_CYCLES, 5000: clk cycles with no PS/2 falling edge mid-frame before the frame is aborted. 100 us at 50 MHz.
- TO_W, 16: timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high. Clears all state.
- ps2_clk, input, 1: raw PS/2 clock line, asynchronous.
- ps2_data, input, 1: raw PS/2 data line, asynchronous.
- key, output, 8: ASCII of the last accepted key. Holds its value between pulses.
- key_valid, output, 1: one-cycle strobe. key is valid while it is high.
- frame_err, output, 1: one-cycle strobe on parity, stop-bit or timeout error.

Behaviour:
- Reset (asynchronous, rst=1):
  - key=0x00, key_valid=0, frame_err=0.
  - FSM=IDLE, bit counter=0, timeout counter=0, brk and ext flags=0.
  - Synchronizer flops and previous-clock flop reset to 1 (bus idle level).
  - Reset mid-frame discards the partial frame. No output strobes.
- Input conditioning:
  - 2-flop synchronizer on each of ps2_clk and ps2_data.
  - fall = previous synced clk 1 AND current synced clk 0.
  - All sampling uses the synced data at cycles where fall=1.
- Frame: 11 bits.
  - start = 0.
  - 8 data bits, LSB first.
  - odd parity: data bits plus parity bit must contain an odd number of ones.
  - stop = 1.
- FSM (advances only on fall, except timeout):
  - IDLE: start bit 0 -> DATA, bit counter=0. Start bit 1 -> stay IDLE, no error.
  - DATA: shift the bit into shreg[7:0] at position counter. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: -> IDLE always.
    - Stop=1 and parity OK: the byte is passed to the decoder at this same edge.
    - Otherwise: frame_err=1 for one cycle, byte discarded, brk=ext=0.
- Timeout:
  - The counter clears on every fall and in IDLE; otherwise it increments each cycle.
  - In a non-IDLE state, reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, brk=ext=0.
  - If fall and the timeout coincide, fall wins.
- Decoder (evaluated on each accepted byte b):
  - b=0xE0: ext=1, no output.
  - b=0xF0: brk=1, no output.
  - Otherwise, if brk=1: key release. Clear brk and ext, no output.
  - Otherwise, if ext=1: clear ext. Output 0x0D only for b=0x5A (keypad enter). All other extended codes are dropped.
  - Otherwise: look b up in the table below. Mapped -> output. Unmapped -> no output.
- Output timing:
  - key and key_valid are registered at the clk edge where fall samples the stop bit.
  - key_valid is therefore high in the following cycle, for exactly one cycle.
  - key_valid and frame_err are never both high.
- Table, lowercase ASCII. Letters a-z (0x61-0x7A):
  - a 1C, b 32, c 21, d 23, e 24, f 2B, g 34
  - h 33, i 43, j 3B, k 42, l 4B, m 3A, n 31
  - o 44, p 4D, q 15, r 2D, s 1B, t 2C, u 3C
  - v 2A, w 1D, x 22, y 35, z 1A
- Table, digits 0-9 (0x30-0x39):
  - 0 45, 1 16, 2 1E, 3 26, 4 25
  - 5 2E, 6 36, 7 3D, 8 3E, 9 46
- Table, other keys:
  - space 29 -> 0x20
  - enter 5A -> 0x0D
- Shift and caps lock are not supported. Typematic repeats produce repeated key_valid pulses.

Test Plan:
- Reset with lines idle at 1 -> key=0x00, key_valid=0, frame_err=0. Assert rst mid-frame after 4 bits, then send a valid 0x1C frame -> key=0x61, exactly one key_valid pulse.
- Send frame 0x1C (parity 0), then F0 and 1C -> exactly one key_valid with key=0x61. The release bytes produce no strobe.
- Send 0x16, 0x1E, 0x5A -> three key_valid pulses with key 0x31, 0x32, 0x0D, in order. Feeding KbBuffer yields buffer_out=0x31320000.
- Send 0x1C with wrong parity (1) -> frame_err pulse, no key_valid. Send 0x1C with stop=0 -> frame_err pulse. A following good 0x24 frame -> key=0x65.
- Send 6 bits, then hold ps2_clk high for TIMEOUT_CYCLES cycles -> single frame_err pulse, FSM back in IDLE. A next good 0x29 frame -> key=0x20.
- Send E0 5A -> key=0x0D. Send E0 75 -> no output. Send unmapped 0x05 -> no output. Send E0 F0 5A -> no output, and brk and ext are both cleared.
